// File: rtl/single_argmax_v.sv
// Sequential arg-max over a captured WIDTH-element binary32 vector, one element per clock.
// Define SINGLE_ARGMAX_NAN_SKIP_EN to keep NaNs from ever displacing a non-NaN best.
module single_argmax_v #(
   parameter int WIDTH = 10,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [31:0]      vector_a [WIDTH],
   output logic             done,
   output logic [IDX_W-1:0] index,
   output logic [31:0]      max_value,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

   state_t           state;
   logic [31:0]      vec [WIDTH];
   logic [31:0]      best;
   logic [IDX_W-1:0] best_idx;
   logic [IDX_W-1:0] ptr;
   logic [31:0]      cand;
   logic             take;

   // Strict greater-than on raw binary32 bits; +0 and -0 are treated as equal.
   function automatic logic fp_greater(input logic [31:0] a, input logic [31:0] b);
      logic result;
      if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
         result = 1'b0;
      else if (a[31] != b[31])
         result = ~a[31];
      else if (!a[31])
         result = (a[30:0] > b[30:0]);
      else
         result = (a[30:0] < b[30:0]);
      return result;
   endfunction

`ifdef SINGLE_ARGMAX_NAN_SKIP_EN
   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction
`endif

   always_comb begin
      cand = vec[ptr];
`ifdef SINGLE_ARGMAX_NAN_SKIP_EN
      if (is_nan(best))
         take = ~is_nan(cand);
      else
         take = ~is_nan(cand) && fp_greater(cand, best);
`else
      take = fp_greater(cand, best);
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         done      <= 1'b0;
         busy      <= 1'b0;
         index     <= '0;
         max_value <= 32'h0;
         best      <= 32'h0;
         best_idx  <= '0;
         ptr       <= '0;
         for (int i = 0; i < WIDTH; i++)
            vec[i] <= 32'h0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < WIDTH; i++)
                     vec[i] <= vector_a[i];
                  best     <= vector_a[0];
                  best_idx <= '0;
                  ptr      <= IDX_W'(1);
                  busy     <= 1'b1;
                  state    <= (WIDTH > 1) ? SCAN : FINISH;
               end
            end
            SCAN: begin
               if (take) begin
                  best     <= cand;
                  best_idx <= ptr;
               end
               ptr <= ptr + IDX_W'(1);
               if (ptr == IDX_W'(WIDTH - 1))
                  state <= FINISH;
            end
            FINISH: begin
               max_value <= best;
               index     <= best_idx;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_single_argmax_v.sv
// Directed bench for single_argmax_v: vector table plus ignored-start, back-to-back and mid-scan reset sequences.
module tb_single_argmax_v;

   localparam int WIDTH = 10;
   localparam int IDX_W = 4;

   typedef logic [WIDTH-1:0][31:0] vec_t;
   typedef struct packed {
      vec_t             v;
      logic [IDX_W-1:0] exp_idx;
      logic [31:0]      exp_val;
   } vector_rec_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic [31:0]      vector_a [WIDTH];
   logic             done;
   logic [IDX_W-1:0] index;
   logic [31:0]      max_value;
   logic             busy;

   int num_applied = 0;
   int num_miscompares = 0;

   vector_rec_t recs [10];
   logic [31:0] f [11];

   single_argmax_v #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .vector_a  (vector_a),
      .done      (done),
      .index     (index),
      .max_value (max_value),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_val);
      num_applied++;
      if (act !== exp_val) begin
         num_miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp_val);
      end
   endtask

   task automatic drive_vector(input vec_t v);
      for (int i = 0; i < WIDTH; i++)
         vector_a[i] = v[i];
   endtask

   function automatic vec_t fill(input logic [31:0] x);
      vec_t r;
      for (int i = 0; i < WIDTH; i++)
         r[i] = x;
      return r;
   endfunction

   // Pulses start with v, zeroes the input afterwards and returns clocks from the start edge to done.
   task automatic apply_stimulus(input vec_t v, output int latency);
      @(negedge clk);
      drive_vector(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_vector('0);
      check_output("busy_after_start", {31'd0, busy}, 32'd1);
      latency = 0;
      while (done !== 1'b1 && latency < 40) begin
         @(negedge clk);
         latency++;
      end
   endtask

   initial begin
      int lat;
      int done_count;
      vec_t va;
      vec_t vb;

      f[0] = 32'h00000000; f[1] = 32'h3F800000; f[2] = 32'h40000000; f[3] = 32'h40400000;
      f[4] = 32'h40800000; f[5] = 32'h40A00000; f[6] = 32'h40C00000; f[7] = 32'h40E00000;
      f[8] = 32'h41000000; f[9] = 32'h41100000; f[10] = 32'h41200000;

      for (int i = 0; i < WIDTH; i++) begin
         recs[0].v[i] = f[i+1];
         recs[1].v[i] = f[10-i];
      end
      recs[0].exp_idx = 4'd9; recs[0].exp_val = 32'h41200000;
      recs[1].exp_idx = 4'd0; recs[1].exp_val = 32'h41200000;

      recs[2].v = fill(32'h3DCCCCCD);
      recs[2].v[0] = 32'h3F000000; recs[2].v[1] = 32'h3F666666; recs[2].v[2] = 32'h3F666666;
      recs[2].exp_idx = 4'd1; recs[2].exp_val = 32'h3F666666;

      recs[3].v = fill(32'hC0800000);
      recs[3].v[0] = 32'hC0400000; recs[3].v[1] = 32'hBF800000; recs[3].v[2] = 32'hC0000000;
      recs[3].exp_idx = 4'd1; recs[3].exp_val = 32'hBF800000;

      recs[4].v = fill(32'hBF800000);
      recs[4].v[0] = 32'h80000000; recs[4].v[1] = 32'h00000000;
      recs[4].exp_idx = 4'd0; recs[4].exp_val = 32'h80000000;

      recs[5].v = fill(32'h3F800000);
      recs[5].v[4] = 32'h7FC00000;
`ifdef SINGLE_ARGMAX_NAN_SKIP_EN
      recs[5].exp_idx = 4'd0; recs[5].exp_val = 32'h3F800000;
`else
      recs[5].exp_idx = 4'd4; recs[5].exp_val = 32'h7FC00000;
`endif

      recs[6].v = fill(32'h3F800000);
      recs[6].v[0] = 32'h7F7FFFFF; recs[6].v[1] = 32'h7F800000;
      recs[6].exp_idx = 4'd1; recs[6].exp_val = 32'h7F800000;

      recs[7].v = fill(32'h00000000);
      recs[7].v[3] = 32'h00000001; recs[7].v[6] = 32'h00000002;
      recs[7].exp_idx = 4'd6; recs[7].exp_val = 32'h00000002;

      recs[8].v = fill(32'hBF800000);
      recs[8].v[9] = 32'h00000000;
      recs[8].exp_idx = 4'd9; recs[8].exp_val = 32'h00000000;

      recs[9].v = fill(32'h3F800000);
      recs[9].v[0] = 32'h7FC00000; recs[9].v[1] = 32'h40400000; recs[9].v[2] = 32'h40000000;
`ifdef SINGLE_ARGMAX_NAN_SKIP_EN
      recs[9].exp_idx = 4'd1; recs[9].exp_val = 32'h40400000;
`else
      recs[9].exp_idx = 4'd0; recs[9].exp_val = 32'h7FC00000;
`endif

      rstn  = 1'b0;
      start = 1'b0;
      drive_vector('0);
      #1;
      check_output("reset_done", {31'd0, done}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_index", {28'd0, index}, 32'd0);
      check_output("reset_max", max_value, 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      for (int k = 0; k < 10; k++) begin
         apply_stimulus(recs[k].v, lat);
         check_output($sformatf("vec%0d_latency", k), lat, 32'd10);
         check_output($sformatf("vec%0d_index", k), {28'd0, index}, {28'd0, recs[k].exp_idx});
         check_output($sformatf("vec%0d_max", k), max_value, recs[k].exp_val);
         @(negedge clk);
         check_output($sformatf("vec%0d_done_width", k), {31'd0, done}, 32'd0);
         check_output($sformatf("vec%0d_busy_idle", k), {31'd0, busy}, 32'd0);
      end

      // Results must hold across idle cycles.
      repeat (3) @(negedge clk);
      check_output("hold_index", {28'd0, index}, {28'd0, recs[9].exp_idx});
      check_output("hold_max", max_value, recs[9].exp_val);

      // Second start three cycles into a scan is ignored.
      vb = fill(32'h40A00000);
      vb[2] = 32'h41100000;
      @(negedge clk);
      drive_vector(recs[0].v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_vector('0);
      lat = 0;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      drive_vector(vb);
      start = 1'b1;
      @(negedge clk);
      lat++;
      start = 1'b0;
      drive_vector('0);
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_output("ignored_start_latency", lat, 32'd10);
      check_output("ignored_start_index", {28'd0, index}, 32'd9);
      check_output("ignored_start_max", max_value, 32'h41200000);
      done_count = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) done_count++;
      end
      check_output("ignored_start_no_second_done", done_count, 32'd0);

      // Back-to-back: start issued during the done cycle is accepted.
      va = recs[1].v;
      apply_stimulus(va, lat);
      check_output("b2b_first_latency", lat, 32'd10);
      drive_vector(vb);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_vector('0);
      check_output("b2b_busy", {31'd0, busy}, 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_output("b2b_second_latency", lat, 32'd10);
      check_output("b2b_second_index", {28'd0, index}, 32'd2);
      check_output("b2b_second_max", max_value, 32'h41100000);

      // Reset five cycles into a scan aborts it.
      @(negedge clk);
      drive_vector(recs[0].v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_vector('0);
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      #1;
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_index", {28'd0, index}, 32'd0);
      check_output("abort_max", max_value, 32'h0);
      check_output("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      done_count = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) done_count++;
      end
      check_output("abort_no_done", done_count, 32'd0);
      check_output("abort_idle_busy", {31'd0, busy}, 32'd0);

      // Recovery after the aborted scan.
      apply_stimulus(recs[3].v, lat);
      check_output("recover_latency", lat, 32'd10);
      check_output("recover_index", {28'd0, index}, 32'd1);
      check_output("recover_max", max_value, 32'hBF800000);

      $display("== %0d vectors applied, %0d miscompares ==", num_applied, num_miscompares);
      $finish;
   end

endmodule

// File: doc/single_argmax_v.md
# single_argmax_v

Sequential arg-max stage for single-precision (IEEE-754 binary32) vectors. It sits directly downstream of `single_softmax_v`. On a `start` pulse it captures the WIDTH-element probability vector that `single_softmax_v` produces, scans it one element per clock, and reports the index and value of the largest element with a one-cycle `done` pulse. Its output is the network's classification result.

## Interface
Parameters:
- `WIDTH`, default 10: number of vector elements; legal range 1..1024.
- `IDX_W`, default `$clog2(WIDTH)` (minimum 1): width of the index output.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rstn` input 1: reset; asynchronous, active-low.
- `start` input 1: one-cycle pulse; captures `vector_a` and begins a scan.
- `vector_a` input [31:0] x WIDTH (unpacked array): input vector, sampled only on an accepted `start`.
- `done` output 1: one-cycle pulse; `index` and `max_value` are valid from this cycle.
- `index` output IDX_W: position of the maximum element.
- `max_value` output 32: bit pattern of the maximum element.
- `busy` output 1: high while a scan is in progress.

## Operation
- Reset values: `done`=0, `busy`=0, `index`=0, `max_value`=32'h0. The FSM is in IDLE and the captured vector is cleared.
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - With `start`=1: latch all WIDTH elements, set best = element 0, best_idx = 0, ptr = 1, `busy`=1.
  - Next state is SCAN if WIDTH>1, else FINISH.
- SCAN:
  - Each cycle, compare element[ptr] against best.
  - If element[ptr] is strictly greater, best/best_idx take element[ptr]/ptr.
  - ptr increments. After processing ptr = WIDTH-1, go to FINISH.
- FINISH:
  - Register best into `max_value` and best_idx into `index`.
  - Pulse `done`=1, clear `busy`, return to IDLE.
- Comparison is done on raw binary32 bits. There is no float unit.
  - Both signs clear: the larger unsigned value wins.
  - Both signs set: the smaller unsigned magnitude wins.
  - Signs differ: the positive operand wins, except +0 and -0, which compare equal.
- Ties (equal values): the earlier index is kept, because the comparison is strictly greater-than. Denormals compare by bit ordering; no flushing.
- `start` while `busy`=1 is ignored. No restart and no re-capture.
- `vector_a` may change freely after the `start` cycle. The scan uses only the captured copy.
- `index` and `max_value` hold their last result until the next FINISH.
- Reset asserted mid-scan aborts immediately and all outputs return to their reset values.

## Timing
- Let E0 be the rising edge that samples `start`=1.
- Edges E1..E(WIDTH-1) process elements 1..WIDTH-1.
- Edge E(WIDTH) performs FINISH: `done` is high for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- Latency from the start edge to the done edge is WIDTH clocks (WIDTH=1 gives 1 clock).
- `busy` is high from E0 until E(WIDTH).
- Back-to-back: a `start` sampled in the `done` cycle (at E(WIDTH+1)) is accepted. Minimum issue interval is WIDTH+1 clocks.
- Fully synchronous outputs; no combinational path from input to output.

## Configuration
- Macro: `SINGLE_ARGMAX_NAN_SKIP_EN`.
- Defined:
  - A NaN (exponent 8'hFF, mantissa ≠ 0) never becomes best once best is non-NaN.
  - If element 0 is NaN, the first non-NaN element replaces it unconditionally.
  - If all elements are NaN, the result is index 0 with element 0's bits.
  - ±Inf compare normally.
- Undefined: NaNs are ordered purely by the raw bit rule above. For example, 32'h7FC00000 beats every positive finite value and +Inf.

## Test plan
- Softmax-like ascending input 1.0, 2.0 … 10.0 (WIDTH=10), `start` for one cycle, vector zeroed afterward -> `done` 10 clocks after the start edge, `index`=9, `max_value`=32'h41200000.
- Descending 10.0 … 1.0 -> `index`=0, `max_value`=32'h41200000. Tie {0.5, 0.9, 0.9, 0.1, …} -> `index`=1.
- All negative {-3.0, -1.0, -2.0, …, -4.0} -> `index`=1, `max_value`=32'hBF800000.
- Vector {-0.0, +0.0, rest -1.0} -> `index`=0, `max_value`=32'h80000000.
- NaN at element 4, 1.0 elsewhere:
  - Macro defined -> `index`=0, `max_value`=32'h3F800000.
  - Macro undefined -> `index`=4, `max_value`=32'h7FC00000.
- Second `start` 3 cycles into a scan -> ignored and the first result is unchanged. `rstn` low 5 cycles into a later scan -> `busy`=0, `index`=0, `max_value`=0 asynchronously, and no `done` pulse.
